// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I R/I/S/B/J field bundles into 32-bit instruction
// words, tags each with a sequential word address and buffers them in a
// 2-entry output FIFO.
// Optional feature: define ENC_RANGE_CHECK_EN to flag immediates that do not
// fit their format (stored as NOP with err set). Undefined: imm_i truncates.
module instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        fmt_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [31:0]       imm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              err_o
);

  localparam logic [2:0]  FMT_R = 3'd0;
  localparam logic [2:0]  FMT_I = 3'd1;
  localparam logic [2:0]  FMT_S = 3'd2;
  localparam logic [2:0]  FMT_B = 3'd3;
  localparam logic [2:0]  FMT_J = 3'd4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic              err;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       instr;
  } entry_t;

  entry_t            head;
  entry_t            tail;
  entry_t            incoming;
  logic [1:0]        count;
  logic [ADDR_W-1:0] next_addr;
  logic [31:0]       word;
  logic              bad;
  logic              push;
  logic              pop;

`ifdef ENC_RANGE_CHECK_EN
  logic imm_ok;

  // Immediate fits its format: upper bits are a pure sign extension (and even for B/J)
  always_comb begin
    imm_ok = 1'b1;
    case (fmt_i)
      FMT_I, FMT_S: imm_ok = (&imm_i[31:11]) | ~(|imm_i[31:11]);
      FMT_B:        imm_ok = ((&imm_i[31:12]) | ~(|imm_i[31:12])) & ~imm_i[0];
      FMT_J:        imm_ok = ((&imm_i[31:20]) | ~(|imm_i[31:20])) & ~imm_i[0];
      default:      imm_ok = 1'b1;
    endcase
  end
`else
  logic unused_imm;
  assign unused_imm = ^{imm_i[31:21], imm_i[0]};
`endif

  // Field packing per format; illegal formats become a flagged NOP
  always_comb begin
    word = NOP;
    bad  = 1'b0;
    case (fmt_i)
      FMT_R: word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_S: word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FMT_B: word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                     imm_i[4:1], imm_i[11], opcode_i};
      FMT_J: word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
      default: begin
        word = NOP;
        bad  = 1'b1;
      end
    endcase
`ifdef ENC_RANGE_CHECK_EN
    if (!imm_ok) begin
      word = NOP;
      bad  = 1'b1;
    end
`endif
  end

  assign incoming    = '{err: bad, addr: next_addr, instr: word};
  assign in_ready_o  = (count != 2'd2) && !clear_i;
  assign out_valid_o = (count != 2'd0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign instr_o     = head.instr;
  assign addr_o      = head.addr;
  assign err_o       = head.err;

  // Shift-style FIFO: head is always the output entry; simultaneous push/pop
  // can only occur at occupancy 1, where the new word replaces the head.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      next_addr <= BASE_ADDR;
    end else if (clear_i) begin
      count     <= '0;
      next_addr <= BASE_ADDR;
    end else begin
      if (push) next_addr <= next_addr + ADDR_W'(4);
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= incoming;
          else               tail <= incoming;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11:   head <= incoming;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: queue-based reference model, one
// per-cycle compare process, directed literal checks plus random traffic.
// A second instance with ADDR_W=4 checks address wrap on the same stimulus.
module tb_instr_encoder;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        out_ready_i = 1'b0;
  logic [2:0]  fmt_i = '0;
  logic [6:0]  opcode_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [6:0]  funct7_i = '0;
  logic [4:0]  rd_i = '0;
  logic [4:0]  rs1_i = '0;
  logic [4:0]  rs2_i = '0;
  logic [31:0] imm_i = '0;

  logic        in_ready_o, out_valid_o, err_o;
  logic [31:0] instr_o, addr_o;
  logic        in_ready_w, out_valid_w, err_w;
  logic [31:0] instr_w;
  logic [3:0]  addr_w;

  int compared = 0;
  int mismatched = 0;

  always #5 clk_i = ~clk_i;

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .fmt_i(fmt_i), .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
    .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .instr_o(instr_o), .addr_o(addr_o), .err_o(err_o)
  );

  instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'h0)) dut_w (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_w),
    .fmt_i(fmt_i), .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
    .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
    .out_valid_o(out_valid_w), .out_ready_i(out_ready_i),
    .instr_o(instr_w), .addr_o(addr_w), .err_o(err_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_addr = BASE;

  function automatic void model_word(output logic [31:0] w, output logic e);
    int v;
    bit ok;
    v = $signed(imm_i);
    e = 1'b0;
    case (fmt_i)
      3'd0: w = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      3'd1: w = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      3'd2: w = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      3'd3: w = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], opcode_i};
      3'd4: w = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
      default: begin w = NOP; e = 1'b1; end
    endcase
    ok = 1'b1;
`ifdef ENC_RANGE_CHECK_EN
    case (fmt_i)
      3'd1, 3'd2: ok = (v >= -2048) && (v <= 2047);
      3'd3:       ok = (v >= -4096) && (v <= 4094) && (v % 2 == 0);
      3'd4:       ok = (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
      default:    ok = 1'b1;
    endcase
`endif
    if (!ok) begin w = NOP; e = 1'b1; end
  endfunction

  initial begin
    logic [31:0] w;
    logic        e;
    bit          acc;
    forever begin
      @(posedge clk_i or negedge rst_i);
      if (!rst_i) begin
        q.delete();
        m_addr = BASE;
      end else if (clear_i) begin
        q.delete();
        m_addr = BASE;
      end else begin
        acc = in_valid_i && (q.size() < 2);
        if (q.size() > 0 && out_ready_i) void'(q.pop_front());
        if (acc) begin
          model_word(w, e);
          q.push_back('{w, m_addr, e});
          m_addr = m_addr + 32'd4;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        check("out_valid", out_valid_o, q.size() != 0);
        check("in_ready", in_ready_o, (q.size() < 2) && !clear_i);
        check("w.out_valid", out_valid_w, q.size() != 0);
        check("w.in_ready", in_ready_w, (q.size() < 2) && !clear_i);
        if (q.size() != 0) begin
          check("instr", instr_o, q[0].instr);
          check("addr", addr_o, q[0].addr);
          check("err", err_o, q[0].err);
          check("w.instr", instr_w, q[0].instr);
          check("w.addr", addr_w, q[0].addr[3:0]);
          check("w.err", err_w, q[0].err);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    fmt_i = f; opcode_i = op; funct3_i = f3; funct7_i = f7;
    rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
    in_valid_i = 1'b1;
  endtask

  task automatic head(input string name, input logic [31:0] ins, input logic [31:0] a,
                      input logic e);
    check({name, ".valid"}, out_valid_o, 1'b1);
    check({name, ".instr"}, instr_o, ins);
    check({name, ".addr"}, addr_o, a);
    check({name, ".err"}, err_o, e);
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($signed($urandom_range(0, 10000)) - 5000);
      2: return 32'($signed($urandom_range(0, 4200000)) - 2100000);
      default: begin
        case ($urandom_range(0, 7))
          0: return 32'd2047;  1: return 32'd2048;
          2: return -32'd2048; 3: return -32'd2049;
          4: return 32'd4094;  5: return -32'd4096;
          6: return 32'd1048574; default: return -32'd1048576;
        endcase
      end
    endcase
  endfunction

  initial begin
    // reset state
    tick(); tick();
    check("rst.out_valid", out_valid_o, 1'b0);
    check("rst.instr", instr_o, 32'h0);
    check("rst.addr", addr_o, 32'h0);
    check("rst.err", err_o, 1'b0);
    rst_i = 1'b1;
    tick();
    check("rst.in_ready", in_ready_o, 1'b1);

    // field packing with FIFO drained each cycle
    out_ready_i = 1'b1;
    drive(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0);       tick();
    head("add", 32'h002081B3, BASE + 0, 1'b0);
    drive(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, -32'd1);      tick();
    head("addi", 32'hFFF10093, BASE + 4, 1'b0);
    drive(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd2, 5'd5, 32'd8);       tick();
    head("sw", 32'h00512423, BASE + 8, 1'b0);
    drive(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, -32'd4);      tick();
    head("beq", 32'hFE000EE3, BASE + 12, 1'b0);
    drive(3'd4, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8);       tick();
    head("jal", 32'h008000EF, BASE + 16, 1'b0);
    in_valid_i = 1'b0; tick();

    // backpressure: two accepted, third waits for a pop
    out_ready_i = 1'b0;
    drive(3'd0, 7'h33, 3'd0, 7'h00, 5'd4, 5'd0, 5'd0, 32'h0);       tick();  // A 0x00000233
    drive(3'd0, 7'h33, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h0);       tick();  // B 0x000002B3
    check("bp.ready_full", in_ready_o, 1'b0);
    drive(3'd0, 7'h33, 3'd0, 7'h00, 5'd6, 5'd0, 5'd0, 32'h0);       tick();  // C 0x00000333
    check("bp.ready_held", in_ready_o, 1'b0);
    head("bp.A_stable", 32'h00000233, BASE + 20, 1'b0);
    out_ready_i = 1'b1; tick();
    head("bp.B", 32'h000002B3, BASE + 24, 1'b0);
    check("bp.ready_after_pop", in_ready_o, 1'b1);
    tick();
    head("bp.C", 32'h00000333, BASE + 28, 1'b0);
    in_valid_i = 1'b0; tick();
    check("bp.drained", out_valid_o, 1'b0);

    // immediate range handling and illegal format
    drive(3'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd2048);    tick();
`ifdef ENC_RANGE_CHECK_EN
    head("i2048", NOP, BASE + 32, 1'b1);
`else
    head("i2048", 32'h80000013, BASE + 32, 1'b0);
`endif
    drive(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd6);       tick();
    head("b6", 32'h00000363, BASE + 36, 1'b0);
    drive(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd5);       tick();
`ifdef ENC_RANGE_CHECK_EN
    head("b5", NOP, BASE + 40, 1'b1);
`else
    head("b5", 32'h00000263, BASE + 40, 1'b0);
`endif
    drive(3'd6, 7'h33, 3'd7, 7'h7F, 5'd9, 5'd9, 5'd9, 32'd1);       tick();
    head("fmt6", NOP, BASE + 44, 1'b1);
    in_valid_i = 1'b0; tick();

    // clear while full with a bundle offered
    out_ready_i = 1'b0;
    drive(3'd0, 7'h33, 3'd0, 7'h00, 5'd1, 5'd1, 5'd1, 32'h0); tick();
    tick();
    clear_i = 1'b1; tick();
    clear_i = 1'b0; in_valid_i = 1'b0;
    check("clr.empty", out_valid_o, 1'b0);
    check("clr.w_empty", out_valid_w, 1'b0);
    out_ready_i = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      drive(3'd1, 7'h13, 3'd0, 7'h00, 5'(i), 5'd0, 5'd0, 32'(i)); tick();
      check("wrap.addr", addr_o, BASE + 32'(4 * i));
      check("wrap.w_addr", addr_w, 4'((4 * i) % 16));
    end
    in_valid_i = 1'b0; tick();

    // asynchronous reset mid-stream
    out_ready_i = 1'b0;
    drive(3'd4, 7'h6F, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd16); tick();
    tick();
    #2 rst_i = 1'b0;
    #1;
    check("arst.out_valid", out_valid_o, 1'b0);
    check("arst.w_out_valid", out_valid_w, 1'b0);
    in_valid_i = 1'b0;
    tick();
    rst_i = 1'b1;
    out_ready_i = 1'b1;
    drive(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0); tick();
    head("arst.first", 32'h002081B3, BASE, 1'b0);
    in_valid_i = 1'b0; tick();

    // random traffic against the model
    for (int unsigned n = 0; n < 4000; n++) begin
      fmt_i       = 3'($urandom_range(0, 7));
      opcode_i    = 7'($urandom);
      funct3_i    = 3'($urandom);
      funct7_i    = 7'($urandom);
      rd_i        = 5'($urandom);
      rs1_i       = 5'($urandom);
      rs2_i       = 5'($urandom);
      imm_i       = rand_imm();
      in_valid_i  = ($urandom_range(0, 9) < 7);
      out_ready_i = ($urandom_range(0, 9) < 6);
      clear_i     = ($urandom_range(0, 99) < 2);
      tick();
    end
    clear_i = 1'b0; in_valid_i = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Packs RV32I instruction fields into 32-bit instruction words, performing the inverse of the immediate-extraction path in the decode stage. Sits between a test/boot sequencer and instruction memory: each accepted field bundle is encoded, tagged with a sequential word address, and buffered in a 2-entry output FIFO for the memory writer. It is also used by benches to generate golden instruction streams.

## Interface

Parameters:
- ADDR_W, 32, width of the word address output.
- BASE_ADDR, 0, address assigned to the first encoded word after reset or clear.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- clear_i  in  1  synchronous restart: flush FIFO, address back to BASE_ADDR.
- in_valid_i  in  1  field bundle valid.
- in_ready_o  out  1  encoder can accept a bundle.
- fmt_i  in  3  format: 0 R, 1 I, 2 S, 3 B, 4 J, 5-7 illegal.
- opcode_i  in  7  opcode field, placed verbatim in bits [6:0].
- funct3_i  in  3  funct3 field.
- funct7_i  in  7  funct7 field, R only.
- rd_i, rs1_i, rs2_i  in  5 each  register indices.
- imm_i  in  32  signed immediate or byte offset.
- out_valid_o  out  1  FIFO head valid.
- out_ready_i  in  1  consumer takes head.
- instr_o  out  32  encoded word at FIFO head.
- addr_o  out  ADDR_W  address of head word.
- err_o  out  1  head word was flagged as unencodable.

## Operation

- Accept: edge where in_valid_i && in_ready_o && !clear_i.
- Packing:
  - R: {funct7, rs2, rs1, f3, rd, op}.
  - I: {imm[11:0], rs1, f3, rd, op}.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - Unused fields are ignored.
- Illegal fmt (5-7): stored word 32'h0000_0013 (addi x0,x0,0), err bit 1.
- Address counter: the entry takes the current count, then count += 4. Wraps modulo 2^ADDR_W. Words flagged err still consume an address.
- FIFO: 2 entries {instr, addr, err}.
  - in_ready_o = !full && !clear_i.
  - Pop when out_valid_o && out_ready_i.
  - Push and pop on the same edge are both performed; occupancy is unchanged.
  - When full, push is blocked; a pop on that edge frees space only for the next cycle (no combinational ready path).
- clear_i has priority over accept and pop: FIFO emptied, counter set to BASE_ADDR.
- Reset values: out_valid_o 0, instr_o 0, addr_o 0, err_o 0, in_ready_o 1 (after rst_i deasserts), counter BASE_ADDR.

## Timing

- Latency 1: a bundle accepted at edge N appears at the head (out_valid_o=1) from edge N onward, when the FIFO was empty.
- Output fields are stable while out_valid_o && !out_ready_i.
- Throughput is 1 word/cycle when out_ready_i is held high.
- Reset mid-stream discards all buffered entries immediately, independent of clk_i.

## Configuration

- ENC_RANGE_CHECK_EN defined:
  - I/S immediates must lie in [-2048, 2047].
  - B immediates must lie in [-4096, 4094] and be even.
  - J immediates must lie in [-1048576, 1048574] and be even.
  - A violating immediate stores the NOP word with err bit 1. R ignores imm_i.
- ENC_RANGE_CHECK_EN undefined: imm_i is silently truncated; err is set only for illegal fmt.

## Test plan

- Field packing, FIFO drained each cycle:
  - R add x3,x1,x2 -> 0x002081B3.
  - I addi x1,x2,-1 -> 0xFFF10093.
  - S sw x5,8(x2) -> 0x00512423.
  - B beq x0,x0,-4 -> 0xFE000EE3.
  - J jal x1,8 -> 0x008000EF.
  - addr_o 0,4,8,12,16; err_o 0 throughout.
- Backpressure: out_ready_i=0, three bundles offered -> two accepted, in_ready_o=0 after second. Raise out_ready_i -> third accepted one cycle after first pop; order and addresses preserved.
- Range check (macro on):
  - I imm=2048 -> instr 0x00000013, err_o=1, address consumed.
  - B imm=6 -> ok. B imm=5 -> err_o=1.
  - Macro off: I imm=2048 -> 0x80000013-class truncation (imm field 0x800), err_o=0.
- Illegal fmt=6 -> 0x00000013, err_o=1, in both macro settings.
- clear_i while full with simultaneous in_valid_i -> FIFO empty next cycle, bundle not accepted, next accepted word at BASE_ADDR. Address wrap with ADDR_W=4: addresses 0,4,8,12,0.
- Assert rst_i low asynchronously mid-stream -> out_valid_o=0 immediately; first post-reset word at BASE_ADDR.
